// File: rtl/mem_port_sequencer.sv
// Single-outstanding memory access sequencer: IDLE -> BUSY -> DONE with registered strobes.
// Optional busy-wait timeout is enabled by defining MEM_PORT_TIMEOUT_EN.
module mem_port_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        select,
   input  logic        permit,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wmask,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_resp,
   input  logic [31:0] mem_rdata,
   output logic        resp,
   output logic [31:0] rdata,
   output logic        error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_r;

`ifdef MEM_PORT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_r;
   logic          error_r;
   assign error = error_r;
`else
   assign error = 1'b0;
`endif

   // Sequencer state, captured request fields, strobes and completion pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_wmask <= 4'h0;
         resp      <= 1'b0;
         rdata     <= 32'h0;
`ifdef MEM_PORT_TIMEOUT_EN
         cnt_r     <= '0;
         error_r   <= 1'b0;
`endif
      end else begin
         resp <= 1'b0;
         case (state_r)
            IDLE: begin
               if (select && permit) begin
                  mem_addr  <= addr;
                  mem_wdata <= wdata;
                  mem_wmask <= wmask;
                  mem_read  <= ~write;
                  mem_write <= write;
                  state_r   <= BUSY;
`ifdef MEM_PORT_TIMEOUT_EN
                  cnt_r     <= '0;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY: begin
               // A response always beats a timeout landing on the same edge
               if (mem_resp) begin
                  if (mem_read) begin
                     rdata <= mem_rdata;
                  end else begin
                     rdata <= rdata;
                  end
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  resp      <= 1'b1;
                  state_r   <= DONE;
`ifdef MEM_PORT_TIMEOUT_EN
               end else if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  resp      <= 1'b1;
                  error_r   <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  cnt_r   <= cnt_r + CW'(1);
                  state_r <= BUSY;
`else
               end else begin
                  state_r <= BUSY;
`endif
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
